// File: rtl/fetch_queue_if.sv
// Bus types and the icache/dispatch-facing interface of fetch_queue.
// master: fetch_queue side; slave: icache/dispatch/branch-unit side.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

endpackage

interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic        branch_mispredict;
  logic [63:0] pc_target;
  logic [63:0] Icache2proc_data;
  logic        Icache2proc_valid;
  logic [63:0] proc2Icache_addr;
  BUS_COMMAND  proc2Icache_command;
  logic [1:0]  dispatch_take;
  logic [31:0] inst0;
  logic [31:0] inst1;
  logic [63:0] pc0;
  logic [63:0] pc1;
  logic [1:0]  inst_valid;

  modport master (
    input  branch_mispredict,
    input  pc_target,
    input  Icache2proc_data,
    input  Icache2proc_valid,
    input  dispatch_take,
    output proc2Icache_addr,
    output proc2Icache_command,
    output inst0,
    output inst1,
    output pc0,
    output pc1,
    output inst_valid
  );

  modport slave (
    output branch_mispredict,
    output pc_target,
    output Icache2proc_data,
    output Icache2proc_valid,
    output dispatch_take,
    input  proc2Icache_addr,
    input  proc2Icache_command,
    input  inst0,
    input  inst1,
    input  pc0,
    input  pc1,
    input  inst_valid
  );

endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, icache line split, circular
// instruction queue feeding 2-wide dispatch, flush on mispredict.
// Ports: clock, reset (sync, active-high), bus (fetch_queue_if.master).
// FETCH_QUEUE_PERF_EN adds perf_full_stall / perf_miss_stall counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0] perf_full_stall,
  output logic [31:0] perf_miss_stall,
`endif
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    REDIRECT = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [63:0]     ent_pc_q   [DEPTH];
  logic [31:0]     ent_inst_q [DEPTH];

  logic [CW-1:0]   free;
  logic            load;
  logic            hit;
  logic            odd;
  logic [1:0]      req;
  logic [1:0]      take;
  logic [1:0]      n_push;
  logic            we0;
  logic            we1;
  logic [AW-1:0]   tail1;
  logic [AW-1:0]   head1;
  logic [31:0]     wdata0;
  logic [63:0]     wpc0;
  logic [63:0]     wpc1;
  logic            unused_bits;

  assign free = CW'(DEPTH) - count_q;
  assign load = (state_q == RUN) && (free >= CW'(2));
  assign odd  = fetch_pc_q[2];
  assign hit  = load && bus.Icache2proc_valid
             && !bus.branch_mispredict;

  // 2'b11 is a 2-wide take; never pop more than is held.
  assign req  = (bus.dispatch_take == 2'b11)
              ? 2'd2 : bus.dispatch_take;
  assign take = (CW'(req) > count_q)
              ? count_q[1:0] : req;

  assign n_push = hit ? (odd ? 2'd1 : 2'd2) : 2'd0;

  // An odd-slot redirect only keeps the upper half of the line.
  assign we0    = hit;
  assign we1    = hit && !odd;
  assign tail1  = tail_q + AW'(1);
  assign wdata0 = odd ? bus.Icache2proc_data[63:32]
                      : bus.Icache2proc_data[31:0];
  assign wpc0   = {fetch_pc_q[63:2], 2'b00};
  assign wpc1   = {fetch_pc_q[63:3], 3'b100};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.branch_mispredict) begin
      state_d    = REDIRECT;
      fetch_pc_d = {bus.pc_target[63:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      state_d = RUN;
      head_d  = head_q + AW'(take);
      tail_d  = tail_q + AW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(take);
      if (hit) begin
        fetch_pc_d = {fetch_pc_q[63:3] + 61'd1, 3'b000};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= REDIRECT;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we0) begin
      ent_pc_q[tail_q]   <= wpc0;
      ent_inst_q[tail_q] <= wdata0;
    end
    if (we1) begin
      ent_pc_q[tail1]   <= wpc1;
      ent_inst_q[tail1] <= bus.Icache2proc_data[63:32];
    end
  end

  assign head1 = head_q + AW'(1);

  assign bus.proc2Icache_addr    = {fetch_pc_q[63:3], 3'b000};
  assign bus.proc2Icache_command = load ? BUS_LOAD : BUS_NONE;
  assign bus.inst0      = ent_inst_q[head_q];
  assign bus.pc0        = ent_pc_q[head_q];
  assign bus.inst1      = ent_inst_q[head1];
  assign bus.pc1        = ent_pc_q[head1];
  assign bus.inst_valid = {count_q >= CW'(2),
                           count_q != '0};

  assign unused_bits = ^{bus.pc_target[1:0],
                         fetch_pc_q[1:0]};

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_full_d = perf_full_q;
    perf_miss_d = perf_miss_q;
    if ((state_q == RUN) && (free < CW'(2))
        && (perf_full_q != 32'hFFFF_FFFF)) begin
      perf_full_d = perf_full_q + 32'd1;
    end
    if (load && !bus.Icache2proc_valid
        && (perf_miss_q != 32'hFFFF_FFFF)) begin
      perf_miss_d = perf_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_q <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_full_q <= perf_full_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_full_stall = perf_full_q;
  assign perf_miss_stall = perf_miss_q;
`endif

endmodule
